// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle-high line) feeding a show-ahead receive FIFO,
// with break detection and sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          msoc_clk,
  input  logic          rstn,
  input  logic          rx,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err,
  output logic          u_break,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  logic          rx_meta_q, rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          cnt_done;
  logic          push, ferr_set;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;
  logic          pop, push_ok;

  assign cnt_done = (cnt_q == '0);

  // Line synchroniser resets to the idle level so reset never fakes a start bit.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    unique case (state_q)
      S_IDLE: begin
        if (brk_q) begin
          if (rx_s_q) brk_d = 1'b0;
        end else if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = FULL_M1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          if (!rx_s_q && shift_q == 8'h00) brk_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state_q == S_STOP && cnt_done) begin
      push     = rx_s_q;
      ferr_set = !rx_s_q && (shift_q != 8'h00);
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign pop     = rd_en && (count_q != '0);
  assign push_ok = push && ((count_q != FULL_C) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + ONE_C;
    else if (!push_ok && pop) count_d = count_q - ONE_C;
    ferr_d = (ferr_q & ~clr_err) | ferr_set;
    ovr_d  = (ovr_q & ~clr_err) | (push & ~push_ok);
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign u_break   = brk_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table-driven frames plus hand-written overrun, full-boundary,
// break and mid-frame reset sequences, with a byte scoreboard on the read side.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          msoc_clk = 1'b0;
  logic          rstn     = 1'b0;
  logic          rx       = 1'b1;
  logic          rd_en    = 1'b0;
  logic          clr_err  = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          frame_err;
  logic          overrun;
  logic          u_break;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[3];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .u_break  (u_break),
    .dbg_state(dbg_state)
  );

  always #5 msoc_clk = ~msoc_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge msoc_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one 10-bit frame; entered just after a rising edge, lasts 10*CPB cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    repeat (24) tick();
  endtask

  task automatic read_check(input string name);
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing (scoreboard empty)", name, rd_data);
    end else begin
      check(name, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_count: 1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_count: 2, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hA5, stop: 1'b0, exp_count: 2, exp_ferr: 1'b1};

    repeat (3) tick();
    check("rst_count",  {28'd0, count}, 32'd0);
    check("rst_valid",  {31'd0, rd_valid}, 32'd0);
    check("rst_data",   {24'd0, rd_data}, 32'd0);
    check("rst_break",  {31'd0, u_break}, 32'd0);
    rstn = 1'b1;
    repeat (5) tick();

    for (int v = 0; v < 3; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      repeat (24) tick();
      check($sformatf("vec%0d_count", v), {28'd0, count}, 32'(vecs[v].exp_count));
      check($sformatf("vec%0d_ferr", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("vec%0d_ovr", v), {31'd0, overrun}, 32'd0);
    end
    read_check("byte0");
    check("after_pop1_count", {28'd0, count}, 32'd1);
    read_check("byte1");
    check("after_pop2_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pop_count", {28'd0, count}, 32'd0);
    pulse_clr();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (20) tick();
    check("glitch_state", {30'd0, dbg_state}, 32'd0);
    check("glitch_count", {28'd0, count}, 32'd0);
    check("glitch_ferr",  {31'd0, frame_err}, 32'd0);
    check("glitch_ovr",   {31'd0, overrun}, 32'd0);

    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check("ovr_count", {28'd0, count}, 32'd8);
    check("ovr_flag",  {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 8; i++) read_check($sformatf("ovr_drain%0d", i));
    check("ovr_drained", {31'd0, rd_valid}, 32'd0);
    pulse_clr();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    for (int i = 1; i <= 8; i++) send_good(8'(i));
    fork
      send_frame(8'h09, 1'b1);
      begin
        repeat (9 * CPB + CPB - 6) tick();
        check("bnd_head", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        exp_q.push_back(8'h09);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end
    join
    repeat (24) tick();
    check("bnd_count", {28'd0, count}, 32'd8);
    check("bnd_ovr",   {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 7; i++) read_check($sformatf("bnd_drain%0d", i));
    check("bnd_last", {24'd0, rd_data}, 32'h09);
    read_check("bnd_drain7");

    send_good(8'h77);
    rx = 1'b0;
    repeat (20 * CPB) tick();
    check("brk_set",   {31'd0, u_break}, 32'd1);
    check("brk_count", {28'd0, count}, 32'd1);
    check("brk_ferr",  {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    repeat (3) tick();
    check("brk_clear", {31'd0, u_break}, 32'd0);
    repeat (20) tick();

    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = 8'h3C >> i;
      repeat (CPB) tick();
    end
    rx = 1'b1;
    repeat (CPB / 2) tick();
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_count", {28'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_data",  {24'd0, rd_data}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    check("mid_rst_break", {31'd0, u_break}, 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (5) tick();
    send_good(8'h3C);
    check("post_rst_count", {28'd0, count}, 32'd1);
    read_check("post_rst_byte");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver with a receive FIFO that sits directly upstream of minion_soc's uart_rx path. It deserialises the external line and presents buffered bytes to the SoC UART register interface. It also generates the u_break indication and sticky framing and overrun error flags. Format is fixed at 8N1, LSB first, idle-high line.

Parameters:
CLKS_PER_BIT, 16, msoc_clk cycles per bit period; even number, minimum 4.
DEPTH, 8, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
msoc_clk  in  1  system clock; all logic in this single domain.
rstn  in  1  asynchronous active-low reset.
rx  in  1  serial line, asynchronous to msoc_clk, idle high.
rd_en  in  1  pop request for the head entry.
rd_data  out  8  FIFO head byte, show-ahead; valid only while rd_valid=1.
rd_valid  out  1  FIFO non-empty.
count  out  AW+1  current FIFO occupancy, 0..DEPTH.
frame_err  out  1  sticky: a frame was received with stop bit = 0 and nonzero data.
overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
clr_err  in  1  synchronous clear of frame_err and overrun.
u_break  out  1  break condition currently active.

Behaviour:
- Reset (asynchronous, rstn=0) values:
  - rd_valid=0, count=0, frame_err=0, overrun=0, u_break=0, rd_data=0.
  - FIFO pointers cleared.
  - FSM returns to IDLE.
  - Synchroniser flops reset to 1.
  - A frame in progress when reset asserts is discarded; no partial push occurs.
- Input sampling: rx passes through a 2-flop synchroniser to give rx_s. Only rx_s is used.
- Bit counter counts msoc_clk cycles; bit index runs 0..7.
- IDLE:
  - rx_s=0 -> START, bit counter loaded to CLKS_PER_BIT/2-1.
  - If u_break=1, IDLE waits for rx_s=1 instead; on rx_s=1 it clears u_break.
- START:
  - On counter expiry, sample rx_s.
  - rx_s=1 is treated as a glitch -> IDLE, nothing recorded.
  - rx_s=0 -> DATA, counter reloaded to CLKS_PER_BIT-1.
- DATA:
  - Sample rx_s at each counter expiry and shift into the shift register, LSB first.
  - After the 8th sample -> STOP.
- STOP, sampled at counter expiry, then -> IDLE:
  - stop=1: push the byte on the next cycle.
  - stop=0 and data=0x00: set u_break=1; no push, no frame_err.
  - stop=0 and data!=0: set frame_err=1; no push.
- FIFO push/pop:
  - A push succeeds if count<DEPTH, or if count=DEPTH and a pop occurs in the same cycle.
  - A push that does not succeed drops the byte and sets overrun=1. Existing contents are unchanged.
  - A pop occurs only when rd_en=1 and rd_valid=1. rd_en while empty is ignored, with no underflow.
  - Simultaneous push and pop leaves count unchanged, and both pointers advance.
  - Pointers wrap modulo DEPTH. Full/empty state comes from count.
- Latency: rd_valid rises 1 cycle after the stop-bit sample cycle. rd_data shows the head entry in that same cycle.
- Sticky flags:
  - clr_err=1 clears frame_err and overrun.
  - If clr_err coincides with a new error event, the set wins.
- u_break is a level: asserted from the stop-sample cycle of the break frame until rx_s is seen high in IDLE.

Test Plan:
- Byte reception: CLKS_PER_BIT=16, send 0x55 then 0xA3 -> count=2, rd_data=0x55; pulse rd_en -> rd_data=0xA3, count=1; pulse rd_en again -> rd_valid=0.
- Glitch rejection: rx low for 3 cycles, then high -> FSM back in IDLE, count=0, no flags set.
- Overrun: DEPTH=8, send 9 bytes 0x01..0x09 with no reads -> count=8, overrun=1; drain yields 0x01..0x08. Then clr_err -> overrun=0.
- Full boundary: FIFO full, 9th byte's push cycle coincides with rd_en -> count stays 8, overrun=0, last byte read out is 0x09.
- Framing error and break:
  - Data 0xA5 with stop=0 -> frame_err=1, count unchanged.
  - rx held low for 20 bit times -> u_break=1, no push; it stays 1 until rx returns high, then drops within 3 cycles.
- Reset mid-frame: assert rstn=0 during bit 4 of a frame -> all outputs at reset values; after release, send 0x3C -> received correctly, count=1.
